ram_b: RTL
==========

// Module: ram_b
// PURPOSE
//  Beta (partial-sum) storage for the SCAN polar decoder (L=2, N=1024, P=256).
//  Dual of the alpha store: the PE array writes left-child and right-child beta halves separately.
//  A read returns the whole parent node, one P-element chunk per transfer, for the upward beta pass.
//  Keeps a per-layer node-ready flag so the scheduler knows when both halves of a node are present.
// PARAMETERS
//  Q  6     bits per beta element, two's complement
//  P  256   elements per transfer (PE count)
//  N  1024  code length; layers 1..10, a layer-l node holds 2^l elements
// PORTS
//  clk       in   1    clock, rising edge
//  rst       in   1    synchronous active-high reset
//  b_in      in   P*Q  write data; element i at bits [(i+1)*Q-1:i*Q], low-aligned
//  layer_w   in   5    write layer, 1..10
//  half_w    in   1    0 = left-child half, 1 = right-child half
//  cnta      in   5    write chunk index within the half (layer 10 only: 0..1)
//  w_en      in   1    write enable
//  layer_r   in   5    read layer, 1..10
//  cntb      in   4    read chunk index within the node (layer 9: 0..1, layer 10: 0..3)
//  r_en      in   1    read enable
//  b_out     out  P*Q  node data, low-aligned, unused upper bits zero
//  b_valid   out  1    b_out holds a valid read result
//  node_rdy  out  10   bit l-1 set = both halves of layer l fully written
// BEHAVIOUR
//  - Reset: all storage, b_out, b_valid and node_rdy go to 0 on the next edge. Reset overrides w_en and r_en.
//  - Write, layer l<=8: the half holds h=2^(l-1) elements, taken from b_in[h*Q-1:0].
//    The left half goes to node offset 0 and the right half to offset h. cnta must be 0.
//  - Write, layer 9: b_in (256 elements) goes to offset 0 (left) or 256 (right). cnta must be 0.
//  - Write, layer 10: the chunk goes to offset 512*half_w + 256*cnta, with cnta 0..1.
//  - Illegal write (layer 0 or >10, or cnta out of range): no state change.
//  - Read has a 1-cycle latency.
//    - r_en with a legal address at edge k: b_out and b_valid=1 are registered at edge k.
//      They are visible during cycle k+1.
//    - Layer l<=8: b_out[2^l*Q-1:0] = node; all other bits are 0.
//    - Layer 9: chunk = offset 256*cntb. Layer 10: chunk = offset 256*cntb.
//    - r_en=0, or an illegal read (layer out of range, cntb out of range): b_out=0 and b_valid=0 at the next edge.
//  - Write and read of the same location in one cycle: the read returns the pre-write contents. The write still lands.
//  - Writes and reads to different layers in the same cycle are fully independent.
//  - Half-complete flags, hf[l][side]:
//    - Set by a legal write to that half. For layer 10 only the cnta=1 write sets it.
//    - node_rdy[l-1] = hf[l][0] & hf[l][1], registered.
//  - Clearing: a legal read of the final chunk clears both hf[l] bits.
//    The final chunk is any read for l<=8, cntb=1 for layer 9 and cntb=3 for layer 10.
//    If a write to a half of the same layer coincides with the clear, that half's flag is set; the other is cleared.
//  - Storage contents are never cleared except by rst. Rewriting a half overwrites it.
// STRUCTURE
//  - Shared package polar_pkg holds:
//    - constants Q, P, N and LAYERS=10
//    - function layer_size(l) = 2^l
//    - function chunks_r(l), giving 1 / 2 / 4
//    - function chunks_w(l), giving 1 / 1 / 2
//    - function legal_w(l,cnt) and function legal_r(l,cnt)
//  - Sub-module ram_b_bank #(SIZE): one layer's register storage.
//    - Provides a half-write port with element offset and count, and a chunk-read port.
//    - ram_b instantiates ten banks via generate and muxes the read by layer_r.
//  - The flag/ready logic lives in ram_b.
// TESTING
//  1. Reset: hold rst=1 two cycles with w_en=r_en=1 -> b_out=0, b_valid=0, node_rdy=10'h000.
//  2. Layer 3 write: left 1,2,3,4, then right 5,6,7,8.
//     -> node_rdy[2]=1 after the 2nd write.
//     Then r_en layer 3 -> next cycle b_out elements 0..7 = 1..8, bits [P*Q-1:8*Q]=0, b_valid=1, and node_rdy[2]=0.
//  3. Layer 10: write four chunks filled with 1 (L,c0), 2 (L,c1), 3 (R,c0), 4 (R,c1).
//     -> node_rdy[9] rises only after the 4th write.
//     Back-to-back reads cntb=0..3 return 1,2,3,4 on consecutive cycles; node_rdy[9] clears after cntb=3.
//  4. Layer 5 holds value 7. In one cycle write left=9 and read layer 5 -> b_out shows 7.
//     The next read shows 9 in the left half and 7 in the right half.
//  5. Illegal accesses: write layer 11, write layer 9 cnta=1, read layer 10 cntb=4.
//     -> storage and node_rdy unchanged; the read gives b_valid=0, b_out=0.
//  6. rst mid-node: write layer 4 left half, assert rst one cycle -> node_rdy=0.
//     Writing the right half alone does not set node_rdy[3]; a read returns the left half as 0.

Source files
------------

// File: rtl/polar_pkg.sv
// Shared constants and layer-geometry helpers for the SCAN polar decoder
// storage blocks (beta store uses L=2, N=1024, P=256).
package polar_pkg;

    localparam int Q      = 6;
    localparam int P      = 256;
    localparam int N      = 1024;
    localparam int LAYERS = 10;
    localparam int PQ     = P * Q;

    function automatic int layer_size(input int l);
        return 1 << l;
    endfunction

    // Transfers needed to read a whole node of layer l.
    function automatic int chunks_r(input int l);
        if (l == 10)
            return 4;
        else if (l == 9)
            return 2;
        else
            return 1;
    endfunction

    // Transfers needed to write one half of a node of layer l.
    function automatic int chunks_w(input int l);
        if (l == 10)
            return 2;
        else
            return 1;
    endfunction

    function automatic logic legal_w(input logic [4:0] l, input logic [4:0] cnt);
        int li;
        li = int'(l);
        return (li >= 1) && (li <= LAYERS) && (int'(cnt) < chunks_w(li));
    endfunction

    function automatic logic legal_r(input logic [4:0] l, input logic [3:0] cnt);
        int li;
        li = int'(l);
        return (li >= 1) && (li <= LAYERS) && (int'(cnt) < chunks_r(li));
    endfunction

endpackage

// File: rtl/ram_b_bank.sv
// Register storage for the beta values of one layer: an aligned half-write
// port and an aligned chunk-read port (combinational read of current contents).
module ram_b_bank
    import polar_pkg::*;
#(
    parameter int SIZE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [9:0]               w_off,
    input  logic [9:0]               w_cnt,
    input  logic [((SIZE/2 < P) ? SIZE/2 : P)*Q-1:0] w_data,
    input  logic [9:0]               r_off,
    output logic [((SIZE < P) ? SIZE : P)*Q-1:0]     r_data
);

    localparam int WW     = (SIZE / 2 < P) ? SIZE / 2 : P;
    localparam int RW     = (SIZE < P) ? SIZE : P;

    logic [SIZE*Q-1:0] mem_q;
    logic [SIZE*Q-1:0] mem_d;
    int                slot;

    // Offsets are always multiples of WW, so element i takes write lane i % WW.
    always_comb begin
        mem_d = mem_q;
        if (w_en) begin
            for (int i = 0; i < SIZE; i++) begin
                if ((i >= int'(w_off)) && (i < int'(w_off) + int'(w_cnt)))
                    mem_d[i*Q +: Q] = w_data[(i % WW)*Q +: Q];
            end
        end
    end

    always_comb begin
        r_data = '0;
        slot   = int'(r_off) / RW;
        if (int'(r_off) + RW <= SIZE)
            r_data = mem_q[slot*RW*Q +: RW*Q];
    end

    always_ff @(posedge clk) begin
        if (rst)
            mem_q <= '0;
        else
            mem_q <= mem_d;
    end

endmodule

// File: rtl/ram_b.sv
// Beta (partial-sum) store: per-layer banks written one child half at a time,
// read back a P-element chunk per cycle, with per-layer node-ready tracking.
module ram_b
    import polar_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PQ-1:0]     b_in,
    input  logic [4:0]        layer_w,
    input  logic              half_w,
    input  logic [4:0]        cnta,
    input  logic              w_en,
    input  logic [4:0]        layer_r,
    input  logic [3:0]        cntb,
    input  logic              r_en,
    output logic [PQ-1:0]     b_out,
    output logic              b_valid,
    output logic [LAYERS-1:0] node_rdy
);

    logic                    w_ok;
    logic                    r_ok;
    logic                    w_last;
    logic                    r_last;
    logic [PQ-1:0]           rd_data [LAYERS];

    logic [PQ-1:0]           b_out_q, b_out_d;
    logic                    b_valid_q, b_valid_d;
    logic [LAYERS-1:0][1:0]  hf_q, hf_d;
    logic [LAYERS-1:0]       node_rdy_q, node_rdy_d;

    always_comb begin
        w_ok   = w_en & legal_w(layer_w, cnta);
        r_ok   = r_en & legal_r(layer_r, cntb);
        w_last = (int'(cnta) == chunks_w(int'(layer_w)) - 1);
        r_last = (int'(cntb) == chunks_r(int'(layer_r)) - 1);
    end

    for (genvar g = 1; g <= LAYERS; g++) begin : g_bank
        localparam int SIZE = 1 << g;
        localparam int WW   = (SIZE / 2 < P) ? SIZE / 2 : P;
        localparam int RW   = (SIZE < P) ? SIZE : P;

        logic          bank_we;
        logic [9:0]    bank_woff;
        logic [9:0]    bank_roff;
        logic [RW*Q-1:0] bank_rd;

        // Right half sits at SIZE/2; cnta only steps the offset on layer 10.
        always_comb begin
            bank_we   = w_ok && (int'(layer_w) == g);
            bank_woff = 10'(int'(half_w) * (SIZE / 2) + int'(cnta) * WW);
            bank_roff = 10'(int'(cntb) * RW);
        end

        ram_b_bank #(.SIZE(SIZE)) u_bank (
            .clk    (clk),
            .rst    (rst),
            .w_en   (bank_we),
            .w_off  (bank_woff),
            .w_cnt  (10'(WW)),
            .w_data (b_in[WW*Q-1:0]),
            .r_off  (bank_roff),
            .r_data (bank_rd)
        );

        assign rd_data[g-1] = PQ'(bank_rd);
    end

    always_comb begin
        b_out_d   = '0;
        b_valid_d = r_ok;
        for (int k = 0; k < LAYERS; k++) begin
            if (r_ok && (int'(layer_r) == k + 1))
                b_out_d = rd_data[k];
        end
    end

    // A final-chunk read clears the node; a coinciding half write wins for its own side.
    always_comb begin
        hf_d = hf_q;
        for (int k = 0; k < LAYERS; k++) begin
            if (r_ok && r_last && (int'(layer_r) == k + 1))
                hf_d[k] = 2'b00;
            if (w_ok && w_last && (int'(layer_w) == k + 1))
                hf_d[k][half_w] = 1'b1;
            node_rdy_d[k] = hf_d[k][0] & hf_d[k][1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_out_q    <= '0;
            b_valid_q  <= 1'b0;
            hf_q       <= '0;
            node_rdy_q <= '0;
        end else begin
            b_out_q    <= b_out_d;
            b_valid_q  <= b_valid_d;
            hf_q       <= hf_d;
            node_rdy_q <= node_rdy_d;
        end
    end

    assign b_out    = b_out_q;
    assign b_valid  = b_valid_q;
    assign node_rdy = node_rdy_q;

endmodule
